piano_key_encoder: RTL and testbench

- Front-end encoder for the electronic piano: takes the seven raw note keys and the octave up/down buttons and produces a single registered note event for the tone generator.
- Output is a note index, an octave, and note-on/note-off strobes.
- It is the encoder counterpart of the key-to-LED display decoder. Both consume the same key set; this block turns key presses into note events instead of lamp drives.

---
 rtl/piano_key_if.sv | 15 +
 rtl/piano_key_encoder.sv | 85 ++++++++
 tb/tb_piano_key_encoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/piano_key_if.sv
// piano_key_if: raw key/button inputs and registered note event outputs of the piano encoder
interface piano_key_if;
  logic c, d, e, f, g, a, b, up, down;
  logic [2:0] note_code;
  logic [2:0] octave;
  logic note_valid, note_on, note_off;
  modport master (
    output c, d, e, f, g, a, b, up, down,
    input note_code, octave, note_valid, note_on, note_off
  );
  modport slave (
    input c, d, e, f, g, a, b, up, down,
    output note_code, octave, note_valid, note_on, note_off
  );
endinterface

// File: rtl/piano_key_encoder.sv
// piano_key_encoder: debounces piano keys and octave buttons into registered note events
module piano_key_encoder #(
  parameter int DEBOUNCE = 16,
  parameter int OCT_RESET = 4,
  parameter int OCT_MAX = 7
) (
  input logic clk,
  input logic rst_n,
  piano_key_if.slave kif
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAYING = 1'b1;
  logic [8:0] raw, s1, s2, st;
  logic [CW-1:0] cnt [9];
  logic [1:0] btn_q;
  logic [0:0] state;
  logic [2:0] code, oct, oct_nxt, win;
  logic valid, on, off, up_rise, dn_rise, oct_chg, any;
  assign raw = {kif.down, kif.up, kif.b, kif.a, kif.g, kif.f, kif.e, kif.d, kif.c};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      st <= '0;
      btn_q <= '0;
      for (int i = 0; i < 9; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      btn_q <= st[8:7];
      for (int i = 0; i < 9; i++) begin
        if (s2[i] == st[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
          st[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end
  assign up_rise = st[7] & ~btn_q[0];
  assign dn_rise = st[8] & ~btn_q[1];
  assign oct_nxt = (up_rise && !dn_rise && oct != 3'(OCT_MAX)) ? oct + 3'd1 :
                   (dn_rise && !up_rise && oct != 3'd0) ? oct - 3'd1 : oct;
  assign oct_chg = oct_nxt != oct;
  assign any = |st[6:0];
  always_comb begin
    win = 3'd0;
    for (int i = 6; i >= 0; i--) if (st[i]) win = 3'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code <= 3'd0;
      oct <= 3'(OCT_RESET);
      valid <= 1'b0;
      on <= 1'b0;
      off <= 1'b0;
    end else begin
      on <= 1'b0;
      off <= 1'b0;
      oct <= oct_nxt;
      if (state == IDLE) begin
        if (any) begin
          code <= win;
          valid <= 1'b1;
          on <= 1'b1;
          state <= PLAYING;
        end
      end else if (!any) begin
        valid <= 1'b0;
        off <= 1'b1;
        state <= IDLE;
      end else if (win != code || oct_chg) begin
        code <= win;
        on <= 1'b1;
      end
    end
  end
  assign kif.note_code = code;
  assign kif.octave = oct;
  assign kif.note_valid = valid;
  assign kif.note_on = on;
  assign kif.note_off = off;
endmodule

// File: tb/tb_piano_key_encoder.sv
// tb_piano_key_encoder: directed vectors with hand-computed expectations, DEBOUNCE=4
module tb_piano_key_encoder;
  logic clk, rst_n;
  int tests = 0, fails = 0;
  int on_cnt = 0, off_cnt = 0, both_cnt = 0;
  int on_ref, off_ref;
  piano_key_if kif();
  piano_key_encoder #(.DEBOUNCE(4), .OCT_RESET(4), .OCT_MAX(7)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kif(kif.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (kif.note_on) on_cnt <= on_cnt + 1;
    if (kif.note_off) off_cnt <= off_cnt + 1;
    if (kif.note_on && kif.note_off) both_cnt <= both_cnt + 1;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input int code, input int oct, input int valid, input int on, input int off);
    chk({tag, ".code"}, int'(kif.note_code), code);
    chk({tag, ".octave"}, int'(kif.octave), oct);
    chk({tag, ".valid"}, int'(kif.note_valid), valid);
    chk({tag, ".on"}, int'(kif.note_on), on);
    chk({tag, ".off"}, int'(kif.note_off), off);
  endtask
  initial begin
    {kif.c, kif.d, kif.e, kif.f, kif.g, kif.a, kif.b, kif.up, kif.down} = '0;
    rst_n = 1'b0;
    step(3);
    chk_out("reset", 0, 4, 0, 0, 0);
    rst_n = 1'b1;
    step(2);
    // 1: single press, 7-cycle latency
    kif.e = 1'b1;
    step(6);
    chk("e_early_on", int'(kif.note_on), 0);
    step(1);
    chk_out("e_press", 2, 4, 1, 1, 0);
    step(1);
    chk("e_pulse_width", int'(kif.note_on), 0);
    step(3);
    // 2: higher-priority key retriggers, release returns to e
    kif.c = 1'b1;
    step(7);
    chk_out("c_over_e", 0, 4, 1, 1, 0);
    step(3);
    kif.c = 1'b0;
    step(7);
    chk_out("c_release", 2, 4, 1, 1, 0);
    chk("no_off_retrig", off_cnt, 0);
    step(3);
    kif.e = 1'b0;
    step(7);
    chk_out("e_release", 2, 4, 0, 0, 1);
    step(3);
    // 3: short glitch is filtered
    on_ref = on_cnt;
    kif.g = 1'b1;
    step(3);
    kif.g = 1'b0;
    step(12);
    chk("glitch_valid", int'(kif.note_valid), 0);
    chk("glitch_no_on", on_cnt, on_ref);
    // 4: octave up with saturation, no strobes in IDLE
    for (int i = 0; i < 4; i++) begin
      kif.up = 1'b1;
      step(10);
      kif.up = 1'b0;
      step(10);
      chk($sformatf("oct_up%0d", i), int'(kif.octave), (i < 3) ? 5 + i : 7);
    end
    kif.up = 1'b1;
    kif.down = 1'b1;
    step(10);
    kif.up = 1'b0;
    kif.down = 1'b0;
    step(10);
    chk("oct_both", int'(kif.octave), 7);
    chk("oct_idle_no_on", on_cnt, on_ref);
    // 5: octave change while playing retriggers
    kif.a = 1'b1;
    step(7);
    chk_out("a_press", 5, 7, 1, 1, 0);
    step(3);
    kif.down = 1'b1;
    step(7);
    chk_out("a_oct_down", 5, 6, 1, 1, 0);
    step(3);
    kif.down = 1'b0;
    step(10);
    kif.a = 1'b0;
    step(7);
    chk_out("a_release", 5, 6, 0, 0, 1);
    step(3);
    // 6: reset mid-note aborts without note_off
    kif.b = 1'b1;
    step(7);
    chk_out("b_press", 6, 6, 1, 1, 0);
    step(3);
    off_ref = off_cnt;
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 0, 4, 0, 0, 0);
    step(3);
    rst_n = 1'b1;
    step(6);
    chk("b_rearm_early", int'(kif.note_on), 0);
    step(1);
    chk_out("b_rearm", 6, 4, 1, 1, 0);
    chk("reset_no_off", off_cnt, off_ref);
    kif.b = 1'b0;
    step(10);
    chk("on_off_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
